// File: rtl/cache_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arb
// Brief    : Shares one memory line-transfer port between I-cache refill and
//            D-cache refill/writeback. Optional stall abort: ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arb #(
  parameter int LINE_WORDS = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [31:0]                   i_addr,
  output logic                          i_gnt,
  output logic [31:0]                   i_rdata,
  output logic                          i_vld,
  output logic [$clog2(LINE_WORDS)-1:0] i_beat,
  output logic                          i_done,
  input  logic                          d_rd_req,
  input  logic                          d_wr_req,
  input  logic [31:0]                   d_addr,
  input  logic [31:0]                   d_wdata,
  output logic                          d_gnt,
  output logic [31:0]                   d_rdata,
  output logic                          d_vld,
  output logic [$clog2(LINE_WORDS)-1:0] d_beat,
  output logic                          d_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_rvld,
  output logic [31:0]                   mem_wdata,
  output logic                          mem_wvld,
  input  logic                          mem_wrdy,
  output logic                          err
);

  localparam int          c_bw        = $clog2(LINE_WORDS);
  localparam int          c_ofs       = $clog2(LINE_WORDS * 4);
  localparam logic [31:0] c_line_mask = ~((32'd1 << c_ofs) - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [c_bw-1:0]   r_cnt;
  logic              r_own_d;
  logic              r_last_d;
  logic              r_we;
  logic              r_gnt_i;
  logic              r_gnt_d;
  logic              r_mem_req;
  logic [31:0]       r_mem_addr;
  logic              r_done_i;
  logic              r_done_d;
  logic              r_err;

  logic              w_any;
  logic              w_pick_d;
  logic              w_rd_beat;
  logic              w_wr_beat;
  logic              w_last;
  logic              w_timeout;

  assign w_any     = i_req | d_rd_req | d_wr_req;
  // Writes always win; a read tie goes to whoever was not served last.
  assign w_pick_d  = d_wr_req | (d_rd_req & (~i_req | ~r_last_d));
  assign w_rd_beat = (r_state == ST_RD) & mem_rvld;
  assign w_wr_beat = (r_state == ST_WR) & mem_wrdy;
  assign w_last    = (r_cnt == c_bw'(LINE_WORDS - 1));

`ifdef ARB_TIMEOUT_EN
  localparam int c_sw = $clog2(TIMEOUT + 1);

  logic [c_sw-1:0] r_stall;
  logic            w_busy;
  logic            w_progress;

  assign w_busy     = (r_state == ST_ADDR) | (r_state == ST_RD) | (r_state == ST_WR);
  assign w_progress = ((r_state == ST_ADDR) & mem_ack) | w_rd_beat | w_wr_beat;
  assign w_timeout  = w_busy & ~w_progress & (r_stall == c_sw'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (!w_busy || w_progress) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + c_sw'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_own_d    <= 1'b0;
      r_last_d   <= 1'b1;
      r_we       <= 1'b0;
      r_gnt_i    <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_done_i   <= 1'b0;
      r_done_d   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done_i <= 1'b0;
      r_done_d <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_ADDR;
            r_own_d    <= w_pick_d;
            r_last_d   <= w_pick_d;
            r_we       <= d_wr_req;
            r_gnt_i    <= ~w_pick_d;
            r_gnt_d    <= w_pick_d;
            r_mem_req  <= 1'b1;
            r_mem_addr <= (w_pick_d ? d_addr : i_addr) & c_line_mask;
          end
        end
        ST_ADDR: begin
          if (w_timeout) begin
            r_state   <= ST_DONE;
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_done_i  <= ~r_own_d;
            r_done_d  <= r_own_d;
            r_err     <= 1'b1;
          end else if (mem_ack) begin
            r_state   <= r_we ? ST_WR : ST_RD;
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ST_RD, ST_WR: begin
          if (w_timeout) begin
            r_state  <= ST_DONE;
            r_cnt    <= '0;
            r_done_i <= ~r_own_d;
            r_done_d <= r_own_d;
            r_err    <= 1'b1;
          end else if (w_rd_beat || w_wr_beat) begin
            // Counter is exactly line-index wide, so the last beat wraps it to 0.
            r_cnt <= r_cnt + c_bw'(1);
            if (w_last) begin
              r_state  <= ST_DONE;
              r_done_i <= ~r_own_d;
              r_done_d <= r_own_d;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_gnt_i <= 1'b0;
          r_gnt_d <= 1'b0;
          r_we    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign i_gnt     = r_gnt_i;
  assign d_gnt     = r_gnt_d;
  assign i_done    = r_done_i;
  assign d_done    = r_done_d;
  assign err       = r_err;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_req & r_we;
  assign mem_addr  = r_mem_addr;

  assign i_vld     = w_rd_beat & ~r_own_d;
  assign d_vld     = w_rd_beat & r_own_d;
  assign i_rdata   = i_vld ? mem_rdata : '0;
  assign d_rdata   = d_vld ? mem_rdata : '0;
  assign i_beat    = r_gnt_i ? r_cnt : '0;
  assign d_beat    = r_gnt_d ? r_cnt : '0;

  assign mem_wvld  = (r_state == ST_WR);
  assign mem_wdata = mem_wvld ? d_wdata : '0;

endmodule
`default_nettype wire

// File: doc/cache_mem_arb.md
Name: cache_mem_arb

Overview:
- Arbitrates the single shared memory/MMU line-transfer port between the I-cache refill path and the D-cache refill and writeback paths.
- Sequences each granted request as one address phase followed by a LINE_WORDS-beat burst.
- Delivers refill beats back to the owning cache and pulls writeback beats from the D-cache.
- Sits between cache_ctrl's i_cache/d_cache instances and the memory interface.

Parameters:
LINE_WORDS, 16, 32-bit words per cache line (power of 2, >=2)
TIMEOUT, 1023, max stall cycles before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
i_req  in  1  I-cache line refill request, held until i_done
i_addr  in  32  I refill address, any byte within the line
i_gnt  out  1  I owns memory port
i_rdata  out  32  refill beat data
i_vld  out  1  i_rdata valid this cycle
i_beat  out  $clog2(LINE_WORDS)  word index of current I beat
i_done  out  1  one-cycle pulse: I transfer complete
d_rd_req  in  1  D-cache line refill request, held until d_done
d_wr_req  in  1  D-cache writeback request, held until d_done
d_addr  in  32  D line address for the request
d_wdata  in  32  writeback word for index d_beat, supplied combinationally by D-cache
d_gnt  out  1  D owns memory port
d_rdata  out  32  refill beat data
d_vld  out  1  d_rdata valid
d_beat  out  $clog2(LINE_WORDS)  current D word index, read or write
d_done  out  1  one-cycle pulse: D transfer complete
mem_req  out  1  address phase valid
mem_we  out  1  1 = write burst, 0 = read burst; valid with mem_req
mem_addr  out  32  line-aligned address
mem_ack  in  1  address phase accepted
mem_rdata  in  32  read beat data
mem_rvld  in  1  read beat valid
mem_wdata  out  32  write beat data
mem_wvld  out  1  write beat valid
mem_wrdy  in  1  write beat accepted when mem_wvld & mem_wrdy
err  out  1  pulse with done when the transfer aborted

Behaviour:
- Reset: state IDLE; beat counter 0; last_owner = D, so I wins the first tie. All outputs 0.
- States: IDLE, ADDR, RD_BURST, WR_BURST, DONE.
- IDLE arbitration, evaluated every cycle, registered into the owner flop:
  - d_wr_req has highest priority.
  - Otherwise, if i_req and d_rd_req are both high, grant the one that is not last_owner (round-robin).
  - Otherwise, grant the single requester.
  - On grant: go to ADDR, update last_owner.
- Grant signals: i_gnt/d_gnt are high from ADDR through DONE inclusive.
- Address: mem_addr = request address with the low $clog2(LINE_WORDS*4) bits zeroed; held constant for the whole transfer.
- ADDR: mem_req = 1, mem_we = (D write). Stay until mem_ack. On mem_ack, go to RD_BURST or WR_BURST and clear the beat counter.
- RD_BURST:
  - Each cycle mem_rvld = 1: owner's vld = 1, rdata = mem_rdata (combinational pass-through), beat = counter; then counter increments.
  - No mem_rvld: no vld; counter holds.
  - Last beat (counter == LINE_WORDS-1 with mem_rvld): go to DONE.
- WR_BURST:
  - mem_wvld = 1, mem_wdata = d_wdata, d_beat = counter.
  - Counter advances only on mem_wrdy.
  - Last accepted beat: go to DONE.
- DONE: owner's done = 1 for exactly one cycle, then IDLE.
  - Requester must deassert req at that clock edge.
  - IDLE does not re-sample the finished requester until the cycle after DONE.
- Counter wrap: counter width exactly $clog2(LINE_WORDS); wraps to 0 at burst end, no extra beat.
- New requests arriving mid-transfer are ignored until IDLE, and the requester holds them. No preemption.
- d_rd_req and d_wr_req both high: write wins; read serviced in a later arbitration.
- Unsolicited mem_rvld outside RD_BURST or mem_wrdy outside WR_BURST: ignored.
- rst mid-transfer: immediate return to reset state on the next edge; the memory side is reset concurrently.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A stall counter runs in ADDR/RD_BURST/WR_BURST. It clears on any progress (mem_ack, mem_rvld, or accepted write beat) and increments otherwise.
  - Reaching TIMEOUT forces DONE with err = 1 alongside done. Beats already delivered are invalid.
  - Stall counter resets to 0 on every grant.
- Not defined: no stall counter, indefinite wait, err tied 0.

Test Plan:
- I refill alone, i_addr=0x0000_1234, LINE_WORDS=16 -> mem_req with mem_we=0, mem_addr=0x0000_1200; 16 mem_rvld beats (data 0x100+n) -> i_vld x16, i_beat 0..15, i_rdata matches; i_done pulse 1 cycle after beat 15; d_* quiet.
- i_req and d_rd_req rise together after reset -> I served first, then D. Both re-requested -> I served first again (last_owner=D). Then D held while I re-requests -> strict alternation.
- d_wr_req, d_rd_req, i_req simultaneous -> write burst first (mem_we=1), then I, then D.
- Write burst, mem_wrdy pattern 1,0,0,1,... -> d_beat holds while wrdy=0; exactly 16 accepted beats with mem_wdata = d_wdata[d_beat]; d_done after beat 15.
- Read burst with rvld gaps plus unsolicited rvld in IDLE -> only in-burst beats counted. rst asserted at beat 7 -> next cycle all outputs 0, IDLE; new i_req re-starts at beat 0.
- ARB_TIMEOUT_EN, TIMEOUT=8, mem_ack never asserted -> after 8 stall cycles: i_done=1 and err=1 same cycle, then IDLE. Without macro: still in ADDR at cycle 100.
